array_2d_row_serializer: RTL and testbench



---
 rtl/array_2d_row_serializer_pkg.sv | 16 +
 rtl/array_2d_row_serializer_if.sv | 34 +++
 rtl/array_2d_row_serializer_counter.sv | 31 +++
 rtl/array_2d_row_serializer.sv | 101 ++++++++++
 tb/tb_array_2d_row_serializer.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/array_2d_row_serializer_pkg.sv
// Shared definitions for the array serializer blocks.
//   clog2_min1         : index width helper, never returns 0
//   serializer_state_t : serializer FSM states
package array_ops_pkg;

   // Index width for n items; a single item still needs a 1-bit index.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } serializer_state_t;

endpackage

// File: rtl/array_2d_row_serializer_if.sv
// Matrix-in / row-out stream bundle for array_2d_row_serializer.
//   in_valid/in_ready/in               : full ROWS x COLS matrix, one per transfer
//   out_valid/out_ready/out_row        : one row of COLS elements per beat
//   out_row_idx/out_last               : row position within the current matrix
// master: the serializer itself. slave: the environment feeding and draining it.
interface array_2d_row_serializer_if #(
   parameter int unsigned BIT_WIDTH = 4,
   parameter int unsigned ROWS      = 8,
   parameter int unsigned COLS      = 8
);
   import array_ops_pkg::*;

   localparam int unsigned ROW_IDX_W = clog2_min1(ROWS);

   logic                 in_valid;
   logic                 in_ready;
   logic [BIT_WIDTH-1:0] in [ROWS][COLS];
   logic                 out_valid;
   logic                 out_ready;
   logic [BIT_WIDTH-1:0] out_row [COLS];
   logic [ROW_IDX_W-1:0] out_row_idx;
   logic                 out_last;

   modport master (
      input  in_valid, in, out_ready,
      output in_ready, out_valid, out_row, out_row_idx, out_last
   );

   modport slave (
      output in_valid, in, out_ready,
      input  in_ready, out_valid, out_row, out_row_idx, out_last
   );

endinterface

// File: rtl/array_2d_row_serializer_counter.sv
// Saturating index counter 0..MAX with synchronous clear.
//   clk, rst : clock, async active-high reset
//   clear    : return to 0 (wins over inc)
//   inc      : advance by one; holds at MAX, never wraps on its own
//   count    : current index
//   at_max   : count == MAX
module bounded_index_counter #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned MAX   = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             inc,
   output logic [WIDTH-1:0] count,
   output logic             at_max
);

   assign at_max = (count == WIDTH'(MAX));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && !at_max) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/array_2d_row_serializer.sv
// Buffers one ROWS x COLS matrix and streams it out one row per accepted beat.
//   clk, rst : clock, async active-high reset
//   bus      : matrix input / row output stream (master side)
// in_ready is the only combinational input-to-output path (through out_ready);
// row data comes straight from the buffer register, never from the input bus.
module array_2d_row_serializer
   import array_ops_pkg::*;
#(
   parameter int unsigned BIT_WIDTH = 4,
   parameter int unsigned ROWS      = 8,
   parameter int unsigned COLS      = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   array_2d_row_serializer_if.master bus
);

   localparam int unsigned ROW_IDX_W = clog2_min1(ROWS);

   serializer_state_t    state;
   serializer_state_t    state_nxt;
   logic [BIT_WIDTH-1:0] mat [ROWS][COLS];
   logic [ROW_IDX_W-1:0] row_idx;
   logic                 at_last;
   logic                 beat;
   logic                 accept;
   logic                 idx_clear;
   logic                 idx_inc;

   // Row pointer into the buffer.
   bounded_index_counter #(
      .WIDTH (ROW_IDX_W),
      .MAX   (ROWS - 1)
   ) u_row_idx (
      .clk    (clk),
      .rst    (rst),
      .clear  (idx_clear),
      .inc    (idx_inc),
      .count  (row_idx),
      .at_max (at_last)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Handshake decode and next state; a new matrix may land on the last beat.
   always_comb begin
      state_nxt     = state;
      bus.out_valid = 1'b0;
      bus.out_last  = 1'b0;
      bus.in_ready  = 1'b0;
      beat          = 1'b0;
      accept        = 1'b0;
      idx_clear     = 1'b0;
      idx_inc       = 1'b0;

      bus.out_valid = (state == ST_BUSY);
      bus.out_last  = bus.out_valid && at_last;
      beat          = bus.out_valid && bus.out_ready;
      bus.in_ready  = !rst && ((state == ST_IDLE) || (beat && at_last));
      accept        = bus.in_valid && bus.in_ready;
      idx_clear     = accept || (beat && at_last);
      idx_inc       = beat && !at_last;

      case (state)
         ST_IDLE: begin
            if (accept) state_nxt = ST_BUSY;
         end
         ST_BUSY: begin
            if (beat && at_last) state_nxt = accept ? ST_BUSY : ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Matrix buffer, loaded whole on acceptance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < int'(ROWS); r++) begin
            for (int c = 0; c < int'(COLS); c++) begin
               mat[r][c] <= '0;
            end
         end
      end else if (accept) begin
         mat <= bus.in;
      end
   end

   // Current row; row_idx never exceeds ROWS-1.
   always_comb begin
      bus.out_row     = mat[row_idx];
      bus.out_row_idx = row_idx;
   end

endmodule

// File: tb/tb_array_2d_row_serializer.sv
// Self-checking bench: a 3x3 instance for the main scenarios and a 1x4 instance
// for the single-row case. Accepted matrices expand into expected beats on a
// scoreboard queue; delivered beats are captured and compared at the end.
module tb_array_2d_row_serializer;

   localparam int unsigned BW = 4;

   typedef struct packed {
      logic [15:0] row;
      logic [1:0]  idx;
      logic        last;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_mis = 0;

   beat_t exp3_q[$];
   beat_t obs3_q[$];
   beat_t exp1_q[$];
   beat_t obs1_q[$];

   always #5 clk = ~clk;

   array_2d_row_serializer_if #(.BIT_WIDTH(BW), .ROWS(3), .COLS(3)) b3 ();
   array_2d_row_serializer_if #(.BIT_WIDTH(BW), .ROWS(1), .COLS(4)) b1 ();

   array_2d_row_serializer #(.BIT_WIDTH(BW), .ROWS(3), .COLS(3)) u3 (
      .clk (clk),
      .rst (rst),
      .bus (b3)
   );

   array_2d_row_serializer #(.BIT_WIDTH(BW), .ROWS(1), .COLS(4)) u1 (
      .clk (clk),
      .rst (rst),
      .bus (b1)
   );

   // Expected row r of a diagonal matrix with value d, element c at bits [4c+3:4c].
   function automatic logic [15:0] diag_row(input logic [3:0] d, input int r, input int cols);
      logic [15:0] v;
      v = '0;
      for (int c = 0; c < cols; c++) if (c == r) v[c*4 +: 4] = d;
      return v;
   endfunction

   function automatic logic [15:0] pack3(input logic [3:0] a0, input logic [3:0] a1,
                                         input logic [3:0] a2);
      return {4'h0, a2, a1, a0};
   endfunction

   task automatic load3(input logic [3:0] d);
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            b3.in[r][c] = (r == c) ? d : 4'h0;
   endtask

   // Scoreboard capture for the 3x3 instance; reset drops undelivered rows.
   always @(negedge clk) begin
      beat_t b;
      if (rst) begin
         while (exp3_q.size() > obs3_q.size()) void'(exp3_q.pop_back());
      end else begin
         if (b3.out_valid && b3.out_ready) begin
            b.row  = pack3(b3.out_row[0], b3.out_row[1], b3.out_row[2]);
            b.idx  = b3.out_row_idx;
            b.last = b3.out_last;
            obs3_q.push_back(b);
         end
         if (b3.in_valid && b3.in_ready) begin
            for (int r = 0; r < 3; r++) begin
               b.row  = pack3(b3.in[r][0], b3.in[r][1], b3.in[r][2]);
               b.idx  = 2'(r);
               b.last = (r == 2);
               exp3_q.push_back(b);
            end
         end
      end
   end

   // Scoreboard capture for the single-row instance.
   always @(negedge clk) begin
      beat_t b;
      if (rst) begin
         while (exp1_q.size() > obs1_q.size()) void'(exp1_q.pop_back());
      end else begin
         if (b1.out_valid && b1.out_ready) begin
            b.row  = {b1.out_row[3], b1.out_row[2], b1.out_row[1], b1.out_row[0]};
            b.idx  = 2'(b1.out_row_idx);
            b.last = b1.out_last;
            obs1_q.push_back(b);
         end
         if (b1.in_valid && b1.in_ready) begin
            b.row  = {b1.in[0][3], b1.in[0][2], b1.in[0][1], b1.in[0][0]};
            b.idx  = 2'd0;
            b.last = 1'b1;
            exp1_q.push_back(b);
         end
      end
   end

   task automatic test_reset();
      logic [15:0] pk;
      load3(4'h5);
      b3.in_valid = 1'b1;
      for (int c = 0; c < 4; c++) b1.in[0][c] = (c == 0) ? 4'hF : 4'h0;
      b1.in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         pk = pack3(b3.out_row[0], b3.out_row[1], b3.out_row[2]);
         n_cmp++; if (b3.in_ready !== 1'b0) begin n_mis++; $display("FAIL reset_in_ready: got %b want 0", b3.in_ready); end
         n_cmp++; if (b3.out_valid !== 1'b0) begin n_mis++; $display("FAIL reset_out_valid: got %b want 0", b3.out_valid); end
         n_cmp++; if (pk !== 16'h0) begin n_mis++; $display("FAIL reset_out_row: got %h want 0000", pk); end
      end
      @(posedge clk); #1;
      rst = 1'b0;
      b3.in_valid = 1'b0;
      b1.in_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (b3.in_ready !== 1'b1) begin n_mis++; $display("FAIL release_in_ready: got %b want 1", b3.in_ready); end
      n_cmp++; if (b3.out_valid !== 1'b0) begin n_mis++; $display("FAIL release_out_valid: got %b want 0", b3.out_valid); end
   endtask

   task automatic test_single();
      logic [15:0] pk;
      @(posedge clk); #1;
      load3(4'h5);
      b3.in_valid  = 1'b1;
      b3.out_ready = 1'b1;
      @(posedge clk); #1;
      b3.in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         pk = pack3(b3.out_row[0], b3.out_row[1], b3.out_row[2]);
         n_cmp++; if (b3.out_valid !== 1'b1) begin n_mis++; $display("FAIL single_valid[%0d]: got %b want 1", k, b3.out_valid); end
         n_cmp++; if (b3.out_row_idx !== 2'(k)) begin n_mis++; $display("FAIL single_idx[%0d]: got %0d want %0d", k, b3.out_row_idx, k); end
         n_cmp++; if (b3.out_last !== (k == 2)) begin n_mis++; $display("FAIL single_last[%0d]: got %b want %b", k, b3.out_last, k == 2); end
         n_cmp++; if (pk !== diag_row(4'h5, k, 3)) begin n_mis++; $display("FAIL single_row[%0d]: got %h want %h", k, pk, diag_row(4'h5, k, 3)); end
      end
      @(negedge clk);
      n_cmp++; if (b3.out_valid !== 1'b0) begin n_mis++; $display("FAIL single_done: got %b want 0", b3.out_valid); end
   endtask

   task automatic test_backpressure();
      logic [15:0] pk, prev_pk;
      logic [1:0]  prev_idx;
      logic        tg, prev_stall;
      int          beats, cyc;
      @(posedge clk); #1;
      load3(4'h7);
      b3.in_valid  = 1'b1;
      b3.out_ready = 1'b0;
      @(posedge clk); #1;
      b3.in_valid = 1'b0;
      tg = 1'b0; prev_stall = 1'b0; beats = 0; cyc = 0;
      prev_pk = '0; prev_idx = '0;
      while (beats < 3 && cyc < 20) begin
         b3.out_ready = tg;
         @(negedge clk);
         pk = pack3(b3.out_row[0], b3.out_row[1], b3.out_row[2]);
         n_cmp++; if (b3.out_valid !== 1'b1) begin n_mis++; $display("FAIL bp_valid[%0d]: got %b want 1", cyc, b3.out_valid); end
         n_cmp++; if (b3.out_row_idx !== 2'(beats)) begin n_mis++; $display("FAIL bp_idx[%0d]: got %0d want %0d", cyc, b3.out_row_idx, beats); end
         n_cmp++; if (b3.in_ready !== (tg && beats == 2)) begin n_mis++; $display("FAIL bp_in_ready[%0d]: got %b want %b", cyc, b3.in_ready, tg && beats == 2); end
         if (prev_stall) begin
            n_cmp++; if (pk !== prev_pk || b3.out_row_idx !== prev_idx) begin
               n_mis++; $display("FAIL bp_hold[%0d]: got %h/%0d want %h/%0d", cyc, pk, b3.out_row_idx, prev_pk, prev_idx);
            end
         end
         prev_pk = pk; prev_idx = b3.out_row_idx; prev_stall = !tg;
         if (tg) beats++;
         tg = !tg;
         cyc++;
         @(posedge clk); #1;
      end
      n_cmp++; if (beats != 3) begin n_mis++; $display("FAIL bp_beats: got %0d want 3", beats); end
      b3.out_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (b3.out_valid !== 1'b0) begin n_mis++; $display("FAIL bp_done: got %b want 0", b3.out_valid); end
   endtask

   task automatic test_back_to_back();
      int   acc, beats, bubbles;
      logic started, pending;
      @(posedge clk); #1;
      load3(4'h5);
      b3.in_valid  = 1'b1;
      b3.out_ready = 1'b1;
      acc = 0; beats = 0; bubbles = 0; started = 1'b0; pending = 1'b0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         @(negedge clk);
         if (b3.out_valid) begin
            n_cmp++; if (b3.out_row_idx !== 2'(beats % 3)) begin n_mis++; $display("FAIL b2b_idx[%0d]: got %0d want %0d", beats, b3.out_row_idx, beats % 3); end
            beats++;
            started = 1'b1;
         end else if (started && beats < 6) begin
            bubbles++;
         end
         if (b3.in_valid && b3.in_ready) begin
            if (acc == 1) begin
               n_cmp++; if (b3.out_last !== 1'b1) begin n_mis++; $display("FAIL b2b_accept_on_last: got %b want 1", b3.out_last); end
            end
            acc++;
            pending = 1'b1;
         end
         @(posedge clk); #1;
         if (pending) begin
            if (acc == 1) load3(4'hA);
            if (acc == 2) b3.in_valid = 1'b0;
            pending = 1'b0;
         end
      end
      n_cmp++; if (acc != 2) begin n_mis++; $display("FAIL b2b_accepts: got %0d want 2", acc); end
      n_cmp++; if (beats != 6) begin n_mis++; $display("FAIL b2b_beats: got %0d want 6", beats); end
      n_cmp++; if (bubbles != 0) begin n_mis++; $display("FAIL b2b_bubbles: got %0d want 0", bubbles); end
   endtask

   task automatic test_reset_mid();
      logic [15:0] pk;
      logic        seen;
      @(posedge clk); #1;
      load3(4'h9);
      b3.in_valid  = 1'b1;
      b3.out_ready = 1'b1;
      @(posedge clk); #1;
      b3.in_valid = 1'b0;
      seen = 1'b0;
      for (int cyc = 0; cyc < 8 && !seen; cyc++) begin
         @(negedge clk);
         if (b3.out_valid && b3.out_row_idx == 2'd1) seen = 1'b1;
      end
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      pk = pack3(b3.out_row[0], b3.out_row[1], b3.out_row[2]);
      n_cmp++; if (!seen) begin n_mis++; $display("FAIL rmid_seen_idx1: got 0 want 1"); end
      n_cmp++; if (b3.out_valid !== 1'b0) begin n_mis++; $display("FAIL rmid_valid: got %b want 0", b3.out_valid); end
      n_cmp++; if (pk !== 16'h0) begin n_mis++; $display("FAIL rmid_row: got %h want 0000", pk); end
      n_cmp++; if (b3.out_row_idx !== 2'd0) begin n_mis++; $display("FAIL rmid_idx: got %0d want 0", b3.out_row_idx); end
      n_cmp++; if (b3.out_last !== 1'b0) begin n_mis++; $display("FAIL rmid_last: got %b want 0", b3.out_last); end
      n_cmp++; if (b3.in_ready !== 1'b0) begin n_mis++; $display("FAIL rmid_in_ready: got %b want 0", b3.in_ready); end
      @(posedge clk); #1;
      rst = 1'b0;
      load3(4'h3);
      b3.in_valid = 1'b1;
      @(posedge clk); #1;
      b3.in_valid = 1'b0;
      @(negedge clk);
      pk = pack3(b3.out_row[0], b3.out_row[1], b3.out_row[2]);
      n_cmp++; if (b3.out_valid !== 1'b1) begin n_mis++; $display("FAIL rmid_restart_valid: got %b want 1", b3.out_valid); end
      n_cmp++; if (b3.out_row_idx !== 2'd0) begin n_mis++; $display("FAIL rmid_restart_idx: got %0d want 0", b3.out_row_idx); end
      n_cmp++; if (pk !== diag_row(4'h3, 0, 3)) begin n_mis++; $display("FAIL rmid_restart_row: got %h want %h", pk, diag_row(4'h3, 0, 3)); end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_rows1();
      logic [15:0] pk;
      @(posedge clk); #1;
      for (int c = 0; c < 4; c++) b1.in[0][c] = (c == 0) ? 4'hF : 4'h0;
      b1.in_valid  = 1'b1;
      b1.out_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (b1.in_ready !== 1'b1) begin n_mis++; $display("FAIL r1_idle_ready: got %b want 1", b1.in_ready); end
      n_cmp++; if (b1.out_valid !== 1'b0) begin n_mis++; $display("FAIL r1_idle_valid: got %b want 0", b1.out_valid); end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         pk = {b1.out_row[3], b1.out_row[2], b1.out_row[1], b1.out_row[0]};
         n_cmp++; if (b1.out_valid !== 1'b1 || b1.out_last !== 1'b1) begin
            n_mis++; $display("FAIL r1_valid_last[%0d]: got %b%b want 11", k, b1.out_valid, b1.out_last);
         end
         n_cmp++; if (b1.out_row_idx !== 1'b0) begin n_mis++; $display("FAIL r1_idx[%0d]: got %0d want 0", k, b1.out_row_idx); end
         n_cmp++; if (pk !== diag_row(4'hF, 0, 4)) begin n_mis++; $display("FAIL r1_row[%0d]: got %h want %h", k, pk, diag_row(4'hF, 0, 4)); end
         n_cmp++; if (b1.in_ready !== 1'b1) begin n_mis++; $display("FAIL r1_in_ready[%0d]: got %b want 1", k, b1.in_ready); end
      end
      @(posedge clk); #1;
      b1.in_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (b1.out_valid !== 1'b1) begin n_mis++; $display("FAIL r1_tail_valid: got %b want 1", b1.out_valid); end
      @(negedge clk);
      n_cmp++; if (b1.out_valid !== 1'b0) begin n_mis++; $display("FAIL r1_done: got %b want 0", b1.out_valid); end
   endtask

   task automatic test_scoreboard();
      n_cmp++; if (obs3_q.size() != exp3_q.size()) begin n_mis++; $display("FAIL sb3_count: got %0d want %0d", obs3_q.size(), exp3_q.size()); end
      n_cmp++; if (exp3_q.size() != 17) begin n_mis++; $display("FAIL sb3_accepted_rows: got %0d want 17", exp3_q.size()); end
      for (int i = 0; i < exp3_q.size() && i < obs3_q.size(); i++) begin
         n_cmp++; if (obs3_q[i] !== exp3_q[i]) begin
            n_mis++; $display("FAIL sb3_beat[%0d]: got %h/%0d/%b want %h/%0d/%b", i, obs3_q[i].row, obs3_q[i].idx,
                              obs3_q[i].last, exp3_q[i].row, exp3_q[i].idx, exp3_q[i].last);
         end
      end
      n_cmp++; if (obs1_q.size() != exp1_q.size() || exp1_q.size() != 5) begin
         n_mis++; $display("FAIL sb1_count: got %0d want %0d (5)", obs1_q.size(), exp1_q.size());
      end
      for (int i = 0; i < exp1_q.size() && i < obs1_q.size(); i++) begin
         n_cmp++; if (obs1_q[i] !== exp1_q[i]) begin
            n_mis++; $display("FAIL sb1_beat[%0d]: got %h/%b want %h/%b", i, obs1_q[i].row, obs1_q[i].last,
                              exp1_q[i].row, exp1_q[i].last);
         end
      end
   endtask

   initial begin
      b3.in_valid  = 1'b0;
      b3.out_ready = 1'b0;
      b1.in_valid  = 1'b0;
      b1.out_ready = 1'b0;
      load3(4'h0);
      for (int c = 0; c < 4; c++) b1.in[0][c] = 4'h0;
      test_reset();
      test_single();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_rows1();
      test_scoreboard();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
